hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard controller that drives the hold/bubble side of the IF/ID and ID/EX pipeline registers. It detects load-use hazards between the instruction in ID and a load in EX, and stalls PC and IF/ID while inserting a bubble into ID/EX. It also detects taken branches resolved in MEM and flushes IF/ID, ID/EX and EX/MEM. Saturating counters for stall and flush events support performance debug.

Parameters:
CNT_W, 16, width of stall/flush event counters (saturating)

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous active-high reset
ID_rs  input  5  rs field of instruction in ID
ID_rt  input  5  rt field of instruction in ID
ID_UsesRt  input  1  ID instruction reads rt as a source (R-type, beq, sw)
EX_MemRead  input  1  instruction in EX is a load
EX_rt  input  5  destination rt of the load in EX
MEM_Branch  input  1  branch instruction in MEM
MEM_Zero  input  1  ALU zero flag of the branch in MEM
PCWrite  output  1  1 = PC may update
IF_ID_Write  output  1  1 = IF/ID may load
ID_EX_Bubble  output  1  1 = ID/EX loads all control bits as 0 this edge
IF_ID_Flush  output  1  1 = IF/ID loads a nop this edge
EX_MEM_Flush  output  1  1 = EX/MEM loads zero control this edge
PCSrc  output  1  1 = PC loads branch target this edge
state  output  2  current FSM state (debug)
stall_cnt  output  CNT_W  number of load-use stall cycles since reset
flush_cnt  output  CNT_W  number of branch flushes since reset

Behaviour:
- Reset (async, rst=1): state=RUN, stall_cnt=0, flush_cnt=0. Outputs take RUN values with no hazard: PCWrite=1, IF_ID_Write=1, all flush/bubble=0, PCSrc=0.
- Combinational terms:
  - taken = MEM_Branch & MEM_Zero.
  - lu_haz = EX_MemRead & (EX_rt != 0) & ((EX_rt == ID_rs) | (ID_UsesRt & (EX_rt == ID_rt))).
- FSM states: RUN=0, STALL=1, FLUSH=2. Code 3 is illegal and returns to RUN on the next edge with RUN outputs.
- RUN:
  - If taken: PCSrc=1, IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Flush=1, PCWrite=1. Next state = FLUSH.
  - Else if lu_haz: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. Next state = STALL.
  - Else: pass-through. Next state = RUN.
- STALL (exactly one cycle; the load is now in MEM):
  - Outputs are pass-through.
  - If taken: apply the RUN taken actions and go to FLUSH.
  - Else if lu_haz (a new load is in EX, which follows from the bubble and only occurs on illegal sequences): stall again and stay in STALL.
  - Else: go to RUN.
- FLUSH (one cycle; wrong-path instructions are already squashed):
  - Outputs are pass-through; taken is ignored in this cycle because the MEM slot holds a flushed bubble.
  - If lu_haz: stall and go to STALL. Else: go to RUN.
- Priority: taken branch beats load-use in every state.
- All outputs except state and the counters are combinational from state and the inputs, valid within the same cycle.
- Counters:
  - stall_cnt increments on each clk edge where the FSM asserted a load-use stall (PCWrite=0).
  - flush_cnt increments on each edge where PCSrc=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-stall or mid-flush returns to RUN immediately (async). Counters clear.
- A hazard on register 0 never stalls.

Test Plan:
1. Reset: rst=1 for 2 cycles, release -> PCWrite=1, IF_ID_Write=1, bubbles/flushes=0, state=0, stall_cnt=0, flush_cnt=0.
2. Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5 -> same cycle PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. Next cycle (EX_MemRead=0) state=1 with pass-through, then state=0; stall_cnt=1.
3. Register 0 and rt gating: EX_MemRead=1, EX_rt=0, ID_rs=0 -> no stall. Then EX_rt=7, ID_rt=7, ID_UsesRt=0 -> no stall. With ID_UsesRt=1 -> stall.
4. Taken branch: MEM_Branch=1, MEM_Zero=1 -> PCSrc=1 and all three flushes=1 for one cycle. Next cycle state=2 with outputs pass-through even if MEM_Branch is still 1. flush_cnt=1.
5. Simultaneous: taken=1 and lu_haz=1 in RUN -> PCSrc=1, PCWrite=1, IF_ID_Write=1, next state=2, stall_cnt unchanged.
6. Saturation and async reset: CNT_W=2, force 5 stalls -> stall_cnt=3. Assert rst mid-STALL (between edges) -> state=0 and counters=0 immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Load-use stall / taken-branch flush controller for the IF/ID, ID/EX and EX/MEM registers.
// Latency: control outputs are combinational in the same cycle; state and counters update on clk.
// Backpressure: a load-use stall holds the PC and IF/ID for one cycle; a taken branch always wins over a stall.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic             MEM_Branch,
    input  logic             MEM_Zero,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             EX_MEM_Flush,
    output logic             PCSrc,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        FLUSH   = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t cur_st;
    state_t nxt_st;

    logic taken;
    logic lu_haz;
    logic do_flush;
    logic do_stall;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign taken  = MEM_Branch & MEM_Zero;
    // $zero is never a real producer, so a load targeting it cannot create a hazard.
    assign lu_haz = EX_MemRead & (EX_rt != 5'd0) &
                    ((EX_rt == ID_rs) | (ID_UsesRt & (EX_rt == ID_rt)));

    always_comb begin
        do_flush = 1'b0;
        do_stall = 1'b0;
        case (cur_st)
            RUN, STALL: begin
                if (taken)       do_flush = 1'b1;
                else if (lu_haz) do_stall = 1'b1;
            end
            // MEM holds the bubble we just inserted, so its branch flags are stale.
            FLUSH: begin
                if (lu_haz) do_stall = 1'b1;
            end
            default: begin
                do_flush = 1'b0;
                do_stall = 1'b0;
            end
        endcase
    end

    always_comb begin
        nxt_st       = RUN;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        PCSrc        = 1'b0;
        if (do_flush) begin
            nxt_st       = FLUSH;
            PCSrc        = 1'b1;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (do_stall) begin
            nxt_st       = STALL;
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st <= RUN;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!PCWrite && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
            if (PCSrc && (flush_cnt != '1))    flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    assign state = cur_st;

endmodule
